// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: command FIFO that issues FP ops one at a time to fpu_16bit and holds each result as a response.
//
// Parameters: DEPTH (FIFO entries, power of 2, >= 2), TIMEOUT (WAIT-cycle abort limit, watchdog build only)
// Optional feature: define FPU_WDOG_EN to enable the WAIT watchdog.
// Ports:
//   clk_i, reset_i            clock (rising edge), synchronous active-high reset
//   cmd_valid_i/cmd_ready_o   command handshake; cmd_ready_o = !full
//   cmd_x_i, cmd_y_i, cmd_op_i  operands and opcode (0 add, 1 sub, 2 mul, 3 div)
//   rsp_valid_o/rsp_ready_i   response handshake
//   rsp_result_o, rsp_ofuf_o, rsp_cmp_o, rsp_op_o, rsp_timeout_o  captured response
//   fpu_x_o, fpu_y_o, fpu_op_o  operands to the FPU, stable from START to capture
//   fpu_start_o               drives the FPU reset port (start pulse)
//   fpu_done_i, fpu_result_i, fpu_ofuf_i, fpu_cmp_i  FPU outputs
//   busy_o                    FSM not idle or FIFO non-empty
//   level_o                   FIFO occupancy
module fpu_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [15:0]            cmd_x_i,
    input  logic [15:0]            cmd_y_i,
    input  logic [1:0]             cmd_op_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [15:0]            rsp_result_o,
    output logic [1:0]             rsp_ofuf_o,
    output logic [2:0]             rsp_cmp_o,
    output logic [1:0]             rsp_op_o,
    output logic                   rsp_timeout_o,
    output logic [15:0]            fpu_x_o,
    output logic [15:0]            fpu_y_o,
    output logic [1:0]             fpu_op_o,
    output logic                   fpu_start_o,
    input  logic                   fpu_done_i,
    input  logic [15:0]            fpu_result_i,
    input  logic [1:0]             fpu_ofuf_i,
    input  logic [2:0]             fpu_cmp_i,
    output logic                   busy_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("fpu_op_sequencer: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, START, ARM, WAIT, HOLD} state_t;

    state_t        state_q, state_d;
    logic [33:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   x_q, x_d, y_q, y_d, res_q, res_d;
    logic [1:0]    op_q, op_d, ofuf_q, ofuf_d, rop_q, rop_d;
    logic [2:0]    cmp_q, cmp_d;
    logic          rv_q, rv_d, to_q, to_d, push, pop, expire;

    assign cmd_ready_o = cnt_q != (AW+1)'(DEPTH);
    assign push        = cmd_valid_i && cmd_ready_o;
    assign pop         = state_q == IDLE && cnt_q != '0;

`ifdef FPU_WDOG_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_q, wd_d;
    // Counts WAIT cycles; zero whenever outside WAIT, so it is clear on WAIT entry.
    assign wd_d   = state_q == WAIT ? wd_q + CW'(1) : '0;
    assign expire = state_q == WAIT && wd_q == CW'(TIMEOUT - 1);
    always_ff @(posedge clk_i) wd_q <= reset_i ? '0 : wd_d;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        wr_d    = push ? wr_q + AW'(1) : wr_q;
        rd_d    = pop ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        op_d    = op_q;
        res_d   = res_q;
        ofuf_d  = ofuf_q;
        cmp_d   = cmp_q;
        rop_d   = rop_q;
        rv_d    = rv_q;
        to_d    = to_q;
        case (state_q)
            IDLE: if (pop) begin
                {op_d, x_d, y_d} = mem_q[rd_q];
                state_d = START;
            end
            START: state_d = ARM;
            // done may still be high from the previous op, so ARM never samples it
            ARM: state_d = WAIT;
            WAIT: if (fpu_done_i) begin
                {res_d, ofuf_d, cmp_d, rop_d, rv_d} = {fpu_result_i, fpu_ofuf_i, fpu_cmp_i, op_q, 1'b1};
                state_d = HOLD;
            end else if (expire) begin
                {res_d, ofuf_d, cmp_d, rop_d, rv_d, to_d} = {16'h7E00, 2'b0, 3'b0, op_q, 1'b1, 1'b1};
                state_d = HOLD;
            end
            HOLD: if (rsp_ready_i) begin
                rv_d    = 1'b0;
                to_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            {wr_q, rd_q, cnt_q} <= '0;
            {x_q, y_q, op_q} <= '0;
            {res_q, ofuf_q, cmp_q, rop_q, rv_q, to_q} <= '0;
        end else begin
            state_q <= state_d;
            {wr_q, rd_q, cnt_q} <= {wr_d, rd_d, cnt_d};
            {x_q, y_q, op_q} <= {x_d, y_d, op_d};
            {res_q, ofuf_q, cmp_q, rop_q, rv_q, to_q} <= {res_d, ofuf_d, cmp_d, rop_d, rv_d, to_d};
        end
    end

    always_ff @(posedge clk_i) if (push) mem_q[wr_q] <= {cmd_op_i, cmd_x_i, cmd_y_i};

    assign fpu_start_o   = reset_i | (state_q == START);
    assign {fpu_x_o, fpu_y_o, fpu_op_o} = {x_q, y_q, op_q};
    assign rsp_valid_o   = rv_q;
    assign rsp_result_o  = res_q;
    assign rsp_ofuf_o    = ofuf_q;
    assign rsp_cmp_o     = cmp_q;
    assign rsp_op_o      = rop_q;
    assign rsp_timeout_o = to_q;
    assign busy_o        = state_q != IDLE || cnt_q != '0;
    assign level_o       = cnt_q;
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: randomized bench with a queue-based reference model and an FPU stub.
module tb_fpu_op_sequencer;
    localparam int DEPTH = 4;
    localparam int TO    = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {logic [1:0] op; logic [15:0] x; logic [15:0] y;} cmd_t;

    logic clk = 0, reset = 1, cmd_valid = 0, rsp_ready = 0, fpu_done = 0;
    logic [15:0] cmd_x = 0, cmd_y = 0;
    logic [1:0]  cmd_op = 0;
    logic cmd_ready, rsp_valid, rsp_timeout, fpu_start, busy;
    logic [15:0] rsp_result, fpu_x, fpu_y, fpu_result;
    logic [1:0]  rsp_ofuf, rsp_op, fpu_op, fpu_ofuf;
    logic [2:0]  rsp_cmp, fpu_cmp;
    logic [LW-1:0] level;

    int total = 0, bad = 0;

    // FPU stand-in: a simple deterministic function of the presented operands
    function automatic logic [15:0] f_res(cmd_t c); return c.x ^ (c.y << 1) ^ {14'b0, c.op}; endfunction
    function automatic logic [1:0]  f_ofuf(cmd_t c); return c.x[1:0] ^ c.y[1:0]; endfunction
    function automatic logic [2:0]  f_cmp(cmd_t c); return c.x[2:0] + {1'b0, c.op}; endfunction

    assign fpu_result = f_res({fpu_op, fpu_x, fpu_y});
    assign fpu_ofuf   = f_ofuf({fpu_op, fpu_x, fpu_y});
    assign fpu_cmp    = f_cmp({fpu_op, fpu_x, fpu_y});

    fpu_op_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TO)) dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_x_i(cmd_x), .cmd_y_i(cmd_y), .cmd_op_i(cmd_op),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result), .rsp_ofuf_o(rsp_ofuf), .rsp_cmp_o(rsp_cmp),
        .rsp_op_o(rsp_op), .rsp_timeout_o(rsp_timeout),
        .fpu_x_o(fpu_x), .fpu_y_o(fpu_y), .fpu_op_o(fpu_op), .fpu_start_o(fpu_start),
        .fpu_done_i(fpu_done), .fpu_result_i(fpu_result), .fpu_ofuf_i(fpu_ofuf), .fpu_cmp_i(fpu_cmp),
        .busy_o(busy), .level_o(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Reference model: queue of pending commands, one op in flight, age = edges since pop
    cmd_t mq[$];
    cmd_t cur;
    bit   act = 0, hold = 0, mto = 0;
    int   age = 0;

    always @(posedge clk) begin
        bit push;
        push = cmd_valid && mq.size() < DEPTH;
        if (reset) begin
            mq.delete();
            act = 0; hold = 0; mto = 0; age = 0;
        end else begin
            if (hold) begin
                if (rsp_ready) begin hold = 0; act = 0; mto = 0; end
            end else if (act) begin
                if (age >= 2 && fpu_done) hold = 1;
`ifdef FPU_WDOG_EN
                else if (age - 1 >= TO) begin hold = 1; mto = 1; end
`endif
                else age++;
            end else if (mq.size() > 0) begin
                cur = mq.pop_front();
                act = 1; age = 0;
            end
            if (push) mq.push_back({cmd_op, cmd_x, cmd_y});
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("level", 32'(level), 32'(mq.size()));
        chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
        chk("busy", 32'(busy), 32'(act || mq.size() > 0));
        chk("fpu_start", 32'(fpu_start), 32'(reset || (act && !hold && age == 0)));
        chk("rsp_valid", 32'(rsp_valid), 32'(hold));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(hold && mto));
        if (act) chk("fpu_operands", {14'b0, fpu_op, fpu_x}, {14'b0, cur.op, cur.x});
        if (act) chk("fpu_y", 32'(fpu_y), 32'(cur.y));
        if (hold) begin
            chk("rsp_result", 32'(rsp_result), 32'(mto ? 16'h7E00 : f_res(cur)));
            chk("rsp_flags", {27'b0, rsp_ofuf, rsp_cmp}, {27'b0, mto ? 2'b0 : f_ofuf(cur), mto ? 3'b0 : f_cmp(cur)});
            chk("rsp_op", 32'(rsp_op), 32'(cur.op));
        end
    end

    // FPU stub timing: start clears done; done rises lat cycles later unless never is set
    bit never = 0;
    int lat = 0, scnt = 0;
    always @(negedge clk) begin
        if (fpu_start) begin
            scnt = 0; fpu_done = 0; lat = $urandom_range(0, 6);
        end else begin
            scnt++;
            fpu_done = !never && scnt > lat;
        end
    end

    task automatic wait_rsp(input string name);
        int i;
        for (i = 0; i < 200 && !rsp_valid; i++) @(negedge clk);
        chk(name, 32'(rsp_valid), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("start_in_reset", 32'(fpu_start), 1);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_level", 32'(level), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fpu_x", 32'(fpu_x), 0);
        chk("rst_rsp_result", 32'(rsp_result), 0);

        // single op, latency pin
        #1 {cmd_valid, cmd_x, cmd_y, cmd_op} = {1'b1, 16'h0F00, 16'h0B80, 2'd0};
        rsp_ready = 1;
        @(negedge clk);
        chk("lat_e0_start", 32'(fpu_start), 0);
        chk("lat_e0_level", 32'(level), 1);
        #1 cmd_valid = 0;
        @(negedge clk);
        chk("lat_e1_start", 32'(fpu_start), 1);
        chk("lat_e1_level", 32'(level), 0);
        wait_rsp("t1_wait");
        chk("t1_result", 32'(rsp_result), 32'h1800);
        chk("t1_op", 32'(rsp_op), 0);

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            #1;
            cmd_valid = $urandom_range(0, 2) != 0;
            cmd_x = 16'($urandom); cmd_y = 16'($urandom); cmd_op = 2'($urandom);
            rsp_ready = $urandom_range(0, 3) != 0;
        end

        // response held 20 cycles with ready low while the FIFO keeps filling
        #1 rsp_ready = 0;
        wait_rsp("hold_wait");
        repeat (20) @(negedge clk);
        #1 rsp_ready = 1; cmd_valid = 0;

        // FIFO fill with FPU never done
        reset = 1; never = 1; rsp_ready = 0;
        @(negedge clk);
        #1 reset = 0;
        @(negedge clk);
        #1 cmd_valid = 1;
        repeat (5) @(negedge clk);
        chk("fill_level", 32'(level), 4);
        chk("fill_ready", 32'(cmd_ready), 0);
        repeat (4) @(negedge clk);
        chk("stall_level", 32'(level), 4);

        // reset mid-operation
        #1 reset = 1; cmd_valid = 0;
        @(negedge clk);
        chk("mid_rst_start", 32'(fpu_start), 1);
        #1 reset = 0;
        @(negedge clk);
        chk("mid_rst_level", 32'(level), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);

`ifdef FPU_WDOG_EN
        #1 {cmd_valid, cmd_x, cmd_y, cmd_op} = {1'b1, 16'h1234, 16'h0042, 2'd3};
        rsp_ready = 1;
        @(negedge clk);
        #1 cmd_valid = 0;
        wait_rsp("wd_wait");
        chk("wd_timeout", 32'(rsp_timeout), 1);
        chk("wd_result", 32'(rsp_result), 32'h7E00);
        @(negedge clk);
        #1 never = 0;
        {cmd_valid, cmd_x, cmd_y, cmd_op} = {1'b1, 16'h0F00, 16'h0B80, 2'd0};
        @(negedge clk);
        #1 cmd_valid = 0;
        wait_rsp("wd_next_wait");
        chk("wd_next_timeout", 32'(rsp_timeout), 0);
        chk("wd_next_result", 32'(rsp_result), 32'h1800);
`endif

        // drain
        #1 never = 0; cmd_valid = 0; rsp_ready = 1;
        for (int i = 0; i < 300 && busy; i++) @(negedge clk);
        chk("drain", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
